pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
Central sequencing block for the 5-stage pipelined RISC-V core (IF/ID/EX/MEM/WB, 64-bit datapath).
- Detects load-use hazards and inserts bubbles.
- Flushes wrong-path instructions on a taken branch.
- Freezes the whole pipeline while data memory is not ready.
- Produces the EX-stage forwarding selects that drive the two 3:1 operand muxes.

Parameters:
REG_ADDR_W, 5, register index width
BRANCH_FLUSH, 2, cycles flush is held after a taken branch (1..3)
MEM_TIMEOUT, 64, max MEM_WAIT cycles before error abort
CNT_W, 32, performance counter width

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs1, id_rs2  in  REG_ADDR_W  source regs of the instruction in ID
ex_rs1, ex_rs2  in  REG_ADDR_W  source regs held in ID/EX
idex_rd  in  REG_ADDR_W  destination in ID/EX
idex_mem_read  in  1  ID/EX instruction is a load
exmem_rd, memwb_rd  in  REG_ADDR_W  destinations in EX/MEM, MEM/WB
exmem_reg_write, memwb_reg_write  in  1  write-back enables
branch_taken  in  1  branch resolved taken (from EX/MEM)
dmem_req  in  1  MEM stage accessing data memory
dmem_ready  in  1  data memory completes this cycle
pc_write  out  1  PC update enable
ifid_write  out  1  IF/ID register enable
idex_bubble  out  1  zero ID/EX control fields
flush  out  1  clear IF/ID and ID/EX
pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
forward_a, forward_b  out  2  operand mux select: 00 reg file, 01 MEM/WB, 10 EX/MEM
mem_err  out  1  sticky timeout flag
ctrl_state  out  2  current FSM state (debug)
stall_cnt, flush_cnt, memwait_cnt  out  CNT_W  performance counters

Behaviour:
- While reset is low (asynchronous):
  - State RUN; counters, mem_err and timeout counter cleared.
  - pc_write = ifid_write = 0; idex_bubble = flush = 1; pipe_hold = 0; forward_a/b = 00.
- FSM states: RUN = 0, LOAD_STALL = 1, MEM_WAIT = 2, FLUSH = 3.
- Outputs are combinational from state plus inputs. The defaults in RUN are pc_write = ifid_write = 1 with all other controls 0.
- RUN priority, highest first:
  1. dmem_req & !dmem_ready: pipe_hold = 1, pc_write = 0, ifid_write = 0; go to MEM_WAIT with timeout counter = 0.
  2. branch_taken: flush = 1, pc_write = 1 (loads the target); go to FLUSH if BRANCH_FLUSH > 1, else stay in RUN.
  3. Load-use hazard (idex_mem_read & idex_rd != 0 & (idex_rd == id_rs1 | idex_rd == id_rs2)): pc_write = 0, ifid_write = 0, idex_bubble = 1; go to LOAD_STALL.
- LOAD_STALL:
  - Defaults apply; hazard detection is suppressed for this one cycle. Return to RUN.
  - Guarantees exactly one bubble per load-use pair.
  - A dmem_req & !dmem_ready in this cycle takes priority exactly as in RUN.
- MEM_WAIT:
  - Holds pipe_hold = 1, pc_write = ifid_write = 0; the timeout counter increments each cycle.
  - When dmem_ready = 1: release in the same cycle (pipe_hold = 0, defaults) and go to RUN.
  - When the counter reaches MEM_TIMEOUT - 1 without ready: set mem_err, release, go to RUN.
  - branch_taken is ignored here. EX/MEM is frozen, so the branch is re-evaluated in RUN.
- FLUSH:
  - flush = 1 for BRANCH_FLUSH - 1 further cycles (down-counter), pc_write = ifid_write = 1; then RUN.
  - A new branch_taken restarts the count.
  - A mem-not-ready event goes to MEM_WAIT; the remaining flush count is discarded.
- Forwarding (combinational, all states):
  - forward_a = 10 if exmem_reg_write & exmem_rd != 0 & exmem_rd == ex_rs1.
  - Else 01 if memwb_reg_write & memwb_rd != 0 & memwb_rd == ex_rs1.
  - Else 00. forward_b is identical using ex_rs2.
  - EX/MEM wins when both stages match.
- mem_err is cleared only by reset.

Optional Feature:
Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on each load-use bubble cycle.
  - flush_cnt increments on each cycle with flush = 1 (reset excluded).
  - memwait_cnt increments on each cycle with pipe_hold = 1.
  - All three saturate at all-ones and clear on reset.
- Undefined: the ports exist and are tied to 0; no counter flops are built.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the state encoding constants;
  - the forward select constants FWD_REGFILE = 00, FWD_MEMWB = 01, FWD_EXMEM = 10;
  - the default REG_ADDR_W.
- Sub-module forward_unit is combinational and instantiated twice (operand A, operand B).

Test Plan:
- Load x5 in EX (idex_mem_read = 1, idex_rd = 5), id_rs2 = 5 -> one cycle with pc_write = 0, ifid_write = 0, idex_bubble = 1; next cycle ctrl_state = 1 with defaults; then RUN.
- idex_rd = 0 with a load and id_rs1 = 0 -> no stall.
- branch_taken = 1 with BRANCH_FLUSH = 2 -> flush = 1 for exactly 2 cycles, pc_write = 1 in both.
- dmem_req = 1 with dmem_ready low for 3 cycles -> pipe_hold = 1 for 3 cycles, released in the cycle ready = 1.
- MEM_TIMEOUT = 4 with ready never asserted -> mem_err = 1 after 4 hold cycles; stays 1 until reset.
- exmem_rd = memwb_rd = 7, both reg_write = 1, ex_rs1 = 7 -> forward_a = 10.
- Same, but exmem_rd = 0 -> forward_a = 01.
- Reset driven low mid-MEM_WAIT -> state RUN immediately, mem_err = 0, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding
// selects and the default register-index width.
package riscv_ctrl_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_FLUSH      = 2'd3
  } ctrl_state_e;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;

endpackage

// File: rtl/pipeline_hazard_controller_forward_unit.sv
// Operand forwarding select for one EX-stage source register. EX/MEM has
// priority over MEM/WB because it holds the younger result.
module forward_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic                  exmem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic                  memwb_reg_write_i,
  output logic [1:0]            fwd_sel_o
);

  always_comb begin
    fwd_sel_o = FWD_REGFILE;
    if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_rs_i)) begin
      fwd_sel_o = FWD_EXMEM;
    end else if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_rs_i)) begin
      fwd_sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard/stall/flush sequencer and forwarding select for the 5-stage core.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W   = REG_ADDR_W_DEFAULT,
  parameter int BRANCH_FLUSH = 2,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic [REG_ADDR_W-1:0] ex_rs1_i,
  input  logic [REG_ADDR_W-1:0] ex_rs2_i,
  input  logic [REG_ADDR_W-1:0] idex_rd_i,
  input  logic                  idex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic                  exmem_reg_write_i,
  input  logic                  memwb_reg_write_i,
  input  logic                  branch_taken_i,
  input  logic                  dmem_req_i,
  input  logic                  dmem_ready_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  idex_bubble_o,
  output logic                  flush_o,
  output logic                  pipe_hold_o,
  output logic [1:0]            forward_a_o,
  output logic [1:0]            forward_b_o,
  output logic                  mem_err_o,
  output logic [1:0]            ctrl_state_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output logic [CNT_W-1:0]      memwait_cnt_o
);

  localparam int TO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
  // The first flush cycle happens in RUN, so FLUSH covers the remaining BRANCH_FLUSH-1.
  localparam logic [1:0] FL_INIT = 2'((BRANCH_FLUSH >= 2) ? (BRANCH_FLUSH - 2) : 0);
  localparam logic       BR_MULTI = (BRANCH_FLUSH > 1);

  ctrl_state_e     state_q, state_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]      fl_cnt_q, fl_cnt_d;
  logic            mem_err_q, mem_err_d;

  logic       mem_stall, load_use, to_done;
  logic [1:0] fwd_a_raw, fwd_b_raw;

  assign mem_stall = dmem_req_i & ~dmem_ready_i;
  assign load_use  = idex_mem_read_i & (idex_rd_i != '0) &
                     ((idex_rd_i == id_rs1_i) | (idex_rd_i == id_rs2_i));
  assign to_done   = (to_cnt_q == TO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_RUN;
      to_cnt_q  <= '0;
      fl_cnt_q  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    mem_err_d = mem_err_q;
    case (state_q)
      ST_RUN, ST_LOAD_STALL: begin
        if (mem_stall) begin
          state_d  = ST_MEM_WAIT;
          to_cnt_d = '0;
        end else if (branch_taken_i) begin
          state_d  = BR_MULTI ? ST_FLUSH : ST_RUN;
          fl_cnt_d = FL_INIT;
        end else if ((state_q == ST_RUN) && load_use) begin
          state_d = ST_LOAD_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        // Branches are not acted on here; EX/MEM is frozen so they resurface in RUN.
        if (dmem_ready_i) begin
          state_d = ST_RUN;
        end else if (to_done) begin
          state_d   = ST_RUN;
          mem_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (mem_stall) begin
          state_d  = ST_MEM_WAIT;
          to_cnt_d = '0;
        end else if (branch_taken_i) begin
          fl_cnt_d = FL_INIT;
        end else if (fl_cnt_q == 2'd0) begin
          state_d = ST_RUN;
        end else begin
          fl_cnt_d = fl_cnt_q - 2'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    flush_o       = 1'b0;
    pipe_hold_o   = 1'b0;
    if (!rst_ni) begin
      pc_write_o    = 1'b0;
      ifid_write_o  = 1'b0;
      idex_bubble_o = 1'b1;
      flush_o       = 1'b1;
    end else begin
      case (state_q)
        ST_RUN, ST_LOAD_STALL, ST_FLUSH: begin
          if (mem_stall) begin
            pipe_hold_o  = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
          end else if (branch_taken_i || (state_q == ST_FLUSH)) begin
            flush_o = 1'b1;
          end else if ((state_q == ST_RUN) && load_use) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (!dmem_ready_i && !to_done) begin
            pipe_hold_o  = 1'b1;
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .ex_rs_i           (ex_rs1_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_reg_write_i (exmem_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .fwd_sel_o         (fwd_a_raw)
  );

  forward_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .ex_rs_i           (ex_rs2_i),
    .exmem_rd_i        (exmem_rd_i),
    .exmem_reg_write_i (exmem_reg_write_i),
    .memwb_rd_i        (memwb_rd_i),
    .memwb_reg_write_i (memwb_reg_write_i),
    .fwd_sel_o         (fwd_b_raw)
  );

  assign forward_a_o  = rst_ni ? fwd_a_raw : FWD_REGFILE;
  assign forward_b_o  = rst_ni ? fwd_b_raw : FWD_REGFILE;
  assign mem_err_o    = mem_err_q;
  assign ctrl_state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q, memwait_cnt_q;

  // Saturating event counters; output events are already masked during reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      memwait_cnt_q <= '0;
    end else begin
      if (idex_bubble_o && (stall_cnt_q != '1))   stall_cnt_q   <= stall_cnt_q + 1'b1;
      if (flush_o && (flush_cnt_q != '1))         flush_cnt_q   <= flush_cnt_q + 1'b1;
      if (pipe_hold_o && (memwait_cnt_q != '1))   memwait_cnt_q <= memwait_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign memwait_cnt_o = memwait_cnt_q;
`else
  assign stall_cnt_o   = '0;
  assign flush_cnt_o   = '0;
  assign memwait_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed scoreboard bench for pipeline_hazard_controller
// (BRANCH_FLUSH = 2, MEM_TIMEOUT = 4).
module tb_pipeline_hazard_controller;

  logic       clk, rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       idex_mem_read, exmem_rw, memwb_rw, branch, dmem_req, dmem_ready;
  logic       pc_write, ifid_write, idex_bubble, flush, pipe_hold, mem_err;
  logic [1:0] fwd_a, fwd_b, ctrl_state;
  logic [31:0] stall_cnt, flush_cnt, memwait_cnt;

  typedef struct {
    int         id;
    logic       pcw, ifw, bub, fl, hold;
    logic [1:0] fa, fb;
    logic       err;
    logic [1:0] st;
    bit         cnt_chk;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  pipeline_hazard_controller #(
    .REG_ADDR_W(5), .BRANCH_FLUSH(2), .MEM_TIMEOUT(4), .CNT_W(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2),
    .idex_rd_i(idex_rd), .idex_mem_read_i(idex_mem_read),
    .exmem_rd_i(exmem_rd), .memwb_rd_i(memwb_rd),
    .exmem_reg_write_i(exmem_rw), .memwb_reg_write_i(memwb_rw),
    .branch_taken_i(branch), .dmem_req_i(dmem_req), .dmem_ready_i(dmem_ready),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .idex_bubble_o(idex_bubble),
    .flush_o(flush), .pipe_hold_o(pipe_hold),
    .forward_a_o(fwd_a), .forward_b_o(fwd_b),
    .mem_err_o(mem_err), .ctrl_state_o(ctrl_state),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .memwait_cnt_o(memwait_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL vec%0d %s actual=%0h expected=%0h", id, name, act, expv);
    end
  endtask

  // Monitor: every mid-cycle sample is one DUT presentation; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.id, "pc_write",    32'(pc_write),    32'(e.pcw));
        chk(e.id, "ifid_write",  32'(ifid_write),  32'(e.ifw));
        chk(e.id, "idex_bubble", 32'(idex_bubble), 32'(e.bub));
        chk(e.id, "flush",       32'(flush),       32'(e.fl));
        chk(e.id, "pipe_hold",   32'(pipe_hold),   32'(e.hold));
        chk(e.id, "forward_a",   32'(fwd_a),       32'(e.fa));
        chk(e.id, "forward_b",   32'(fwd_b),       32'(e.fb));
        chk(e.id, "mem_err",     32'(mem_err),     32'(e.err));
        chk(e.id, "ctrl_state",  32'(ctrl_state),  32'(e.st));
        if (e.cnt_chk) begin
          chk(e.id, "stall_cnt",   stall_cnt,   32'd0);
          chk(e.id, "flush_cnt",   flush_cnt,   32'd0);
          chk(e.id, "memwait_cnt", memwait_cnt, 32'd0);
        end
      end
    end
  end

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0;
    idex_rd = '0; exmem_rd = '0; memwb_rd = '0;
    idex_mem_read = 1'b0; exmem_rw = 1'b0; memwb_rw = 1'b0;
    branch = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Push the hand-computed response for the inputs just driven, then advance one cycle.
  task automatic cyc(input logic pcw, input logic ifw, input logic bub, input logic fl,
                     input logic hold, input logic [1:0] fa, input logic [1:0] fb,
                     input logic err, input logic [1:0] st);
    exp_t e;
    e.id = vec_id; e.pcw = pcw; e.ifw = ifw; e.bub = bub; e.fl = fl; e.hold = hold;
    e.fa = fa; e.fb = fb; e.err = err; e.st = st;
`ifdef HAZARD_PERF_CNT_EN
    e.cnt_chk = !rst_n;
`else
    e.cnt_chk = 1'b1;
`endif
    exp_q.push_back(e);
    vec_id++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;

    // Reset: forwarding forced to register file even with a matching EX/MEM write.
    exmem_rw = 1'b1; exmem_rd = 5'd3; ex_rs1 = 5'd3;
    cyc(0,0,1,1,0, 2'b00,2'b00, 0, 2'd0);
    cyc(0,0,1,1,0, 2'b00,2'b00, 0, 2'd0);
    rst_n = 1'b1; idle();
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd0);

    // Load-use on rs2: one bubble, one LOAD_STALL cycle with hazard suppressed, then RUN.
    idex_mem_read = 1'b1; idex_rd = 5'd5; id_rs2 = 5'd5;
    cyc(0,0,1,0,0, 2'b00,2'b00, 0, 2'd0);
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd1);
    idle();
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd0);
    // Load-use on rs1.
    idex_mem_read = 1'b1; idex_rd = 5'd9; id_rs1 = 5'd9;
    cyc(0,0,1,0,0, 2'b00,2'b00, 0, 2'd0);
    idle();
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd1);
    // x0 load never stalls; matching non-load never stalls.
    idex_mem_read = 1'b1; idex_rd = 5'd0; id_rs1 = 5'd0;
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd0);
    idex_mem_read = 1'b0; idex_rd = 5'd5; id_rs1 = 5'd5;
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd0);
    idle();

    // Taken branch: flush exactly two cycles with pc_write held.
    branch = 1'b1;
    cyc(1,1,0,1,0, 2'b00,2'b00, 0, 2'd0);
    branch = 1'b0;
    cyc(1,1,0,1,0, 2'b00,2'b00, 0, 2'd3);
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd0);
    // Branch beats a load-use hazard; a second branch in FLUSH restarts the count.
    branch = 1'b1; idex_mem_read = 1'b1; idex_rd = 5'd4; id_rs1 = 5'd4;
    cyc(1,1,0,1,0, 2'b00,2'b00, 0, 2'd0);
    idle(); branch = 1'b1;
    cyc(1,1,0,1,0, 2'b00,2'b00, 0, 2'd3);
    branch = 1'b0;
    cyc(1,1,0,1,0, 2'b00,2'b00, 0, 2'd3);
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd0);

    // Memory not ready for 3 cycles, released in the ready cycle; branch ignored in MEM_WAIT.
    dmem_req = 1'b1;
    cyc(0,0,0,0,1, 2'b00,2'b00, 0, 2'd0);
    cyc(0,0,0,0,1, 2'b00,2'b00, 0, 2'd2);
    branch = 1'b1;
    cyc(0,0,0,0,1, 2'b00,2'b00, 0, 2'd2);
    branch = 1'b0; dmem_ready = 1'b1;
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd2);
    idle();
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd0);

    // Timeout: four hold cycles, release, then sticky mem_err.
    dmem_req = 1'b1;
    cyc(0,0,0,0,1, 2'b00,2'b00, 0, 2'd0);
    cyc(0,0,0,0,1, 2'b00,2'b00, 0, 2'd2);
    cyc(0,0,0,0,1, 2'b00,2'b00, 0, 2'd2);
    cyc(0,0,0,0,1, 2'b00,2'b00, 0, 2'd2);
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd2);
    idle();
    cyc(1,1,0,0,0, 2'b00,2'b00, 1, 2'd0);
    cyc(1,1,0,0,0, 2'b00,2'b00, 1, 2'd0);

    // Forwarding.
    exmem_rd = 5'd7; memwb_rd = 5'd7; exmem_rw = 1'b1; memwb_rw = 1'b1; ex_rs1 = 5'd7;
    cyc(1,1,0,0,0, 2'b10,2'b00, 1, 2'd0);
    exmem_rd = 5'd0; ex_rs2 = 5'd7;
    cyc(1,1,0,0,0, 2'b01,2'b01, 1, 2'd0);
    exmem_rd = 5'd7; exmem_rw = 1'b0; ex_rs1 = 5'd2;
    cyc(1,1,0,0,0, 2'b00,2'b01, 1, 2'd0);
    exmem_rd = 5'd2; exmem_rw = 1'b1; memwb_rw = 1'b0;
    cyc(1,1,0,0,0, 2'b10,2'b00, 1, 2'd0);
    idle(); memwb_rw = 1'b1;
    cyc(1,1,0,0,0, 2'b00,2'b00, 1, 2'd0);
    idle();

    // Memory stall arriving during LOAD_STALL takes priority.
    idex_mem_read = 1'b1; idex_rd = 5'd6; id_rs1 = 5'd6;
    cyc(0,0,1,0,0, 2'b00,2'b00, 1, 2'd0);
    dmem_req = 1'b1;
    cyc(0,0,0,0,1, 2'b00,2'b00, 1, 2'd1);
    cyc(0,0,0,0,1, 2'b00,2'b00, 1, 2'd2);
    dmem_ready = 1'b1;
    cyc(1,1,0,0,0, 2'b00,2'b00, 1, 2'd2);
    idle();
    cyc(1,1,0,0,0, 2'b00,2'b00, 1, 2'd0);

    // Memory stall during FLUSH discards the remaining flush.
    branch = 1'b1;
    cyc(1,1,0,1,0, 2'b00,2'b00, 1, 2'd0);
    branch = 1'b0; dmem_req = 1'b1;
    cyc(0,0,0,0,1, 2'b00,2'b00, 1, 2'd3);
    cyc(0,0,0,0,1, 2'b00,2'b00, 1, 2'd2);
    dmem_ready = 1'b1;
    cyc(1,1,0,0,0, 2'b00,2'b00, 1, 2'd2);
    idle();
    cyc(1,1,0,0,0, 2'b00,2'b00, 1, 2'd0);

    // Reset asserted mid-MEM_WAIT: immediate return to RUN with mem_err cleared.
    dmem_req = 1'b1;
    cyc(0,0,0,0,1, 2'b00,2'b00, 1, 2'd0);
    cyc(0,0,0,0,1, 2'b00,2'b00, 1, 2'd2);
    rst_n = 1'b0;
    cyc(0,0,1,1,0, 2'b00,2'b00, 0, 2'd0);
    rst_n = 1'b1; idle();
    cyc(1,1,0,0,0, 2'b00,2'b00, 0, 2'd0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
